// File: rtl/booth_mac_acc.sv
// ---------------------------------------------------------------------------
// booth_mac_acc
//   Dot-product accumulator placed directly after the combinational Booth
//   multiplier `mul`. A run of `len` signed products is summed into a wide
//   two's-complement accumulator. The sum is returned over a valid/ready
//   result interface.
//
//   Configuration macro: BOOTH_MAC_SAT_EN
//     defined   - each add saturates on signed overflow; ovf is a sticky flag
//                 that is cleared by the next accepted start
//     undefined - adds wrap modulo 2**ACC_W; ovf is tied to 0
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   start       in   1       begin a new run (honoured only in IDLE)
//   len         in   CNT_W   products in the run, sampled with start
//   prod_valid  in   1       product presented
//   prod_ready  out  1       product accepted this cycle (state == ACCUM)
//   product     in   PROD_W  signed product from mul
//   acc_valid   out  1       result valid (state == DONE)
//   acc_ready   in   1       consumer accepts result
//   acc_out     out  ACC_W   signed accumulated sum
//   busy        out  1       state != IDLE
//   ovf         out  1       sticky overflow flag for the current run
// ---------------------------------------------------------------------------
module booth_mac_acc #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] product,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              busy,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_nxt;
   logic                    xfer;

   // Handshake outputs are decoded from registered state only, so there is
   // no combinational path from any input to any output.
   assign prod_ready = (state == ACCUM);
   assign acc_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   assign xfer     = prod_valid && prod_ready;
   // Sized cast of a signed operand sign-extends; also valid when ACC_W == PROD_W.
   assign prod_ext = ACC_W'($signed(product));
   assign sum      = acc + prod_ext;

`ifdef BOOTH_MAC_SAT_EN
   logic add_ovf;
   logic ovf_q;

   // Signed overflow: both operands share a sign that the sum does not.
   assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc[ACC_W-1]);

   always_comb begin
      acc_nxt = sum;
      if (add_ovf) begin
         acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == IDLE && start) begin
         ovf_q <= 1'b0;
      end else if (xfer && add_ovf) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign acc_nxt = sum;
   assign ovf     = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt and no
      // latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (xfer && cnt == CNT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // A start arriving on the handoff edge sees DONE, so it is dropped.
            if (acc_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: accumulator and remaining-product counter
   // -------------------------------------------------------------------------
   // NOTE: these are plain registers, not a memory array, so they take the
   // reset; acc is architecturally visible through acc_out right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  cnt <= len;
               end
            end
            ACCUM: begin
               // prod_valid low holds both acc and cnt indefinitely.
               if (xfer) begin
                  acc <= acc_nxt;
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // acc is only written in IDLE (on start) and ACCUM, so the result is
   // frozen through DONE and held in IDLE until the next start.
   assign acc_out = acc;

endmodule
